seq_bit_serializer: RTL

Parallel-to-serial front end feeding the 1011 sequence detector's inp_bit input. Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per clock. A one-word holding register allows gap-free back-to-back streaming. When no data is available, the block drives a defined idle bit and flags the gap in the stream.

---
 rtl/seq_bit_serializer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// emits one bit per clock, with a one-word holding register for gap-free streaming.
module seq_bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             underrun
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam int OUT_IDX = MSB_FIRST ? (WIDTH - 1) : 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sreg_reg, sreg_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic             hold_full_reg, hold_full_next;
  logic             underrun_reg, underrun_next;

  logic [WIDTH-1:0] sreg_shifted;
  logic             transfer;
  logic             last_bit;

  // Shift one position toward the output end, filling the far end with zero.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign sreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign sreg_shifted[gi] = sreg_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign sreg_shifted[gi] = 1'b0;
        end else begin : g_move
          assign sreg_shifted[gi] = sreg_reg[gi+1];
        end
      end
    end
  endgenerate

  assign transfer = in_valid && !hold_full_reg;
  assign last_bit = (cnt_reg == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      sreg_reg      <= '0;
      cnt_reg       <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sreg_reg      <= sreg_next;
      cnt_reg       <= cnt_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      underrun_reg  <= underrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sreg_next      = sreg_reg;
    cnt_next       = cnt_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    underrun_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (transfer) begin
          sreg_next  = in_data;
          cnt_next   = '0;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!last_bit) begin
          sreg_next = sreg_shifted;
          cnt_next  = cnt_reg + CNT_W'(1);
          if (transfer) begin
            hold_next      = in_data;
            hold_full_next = 1'b1;
          end
        end else if (hold_full_reg) begin
          // Queued word drains; in_ready is low here so no load can coincide.
          sreg_next      = hold_reg;
          hold_full_next = 1'b0;
          cnt_next       = '0;
        end else if (transfer) begin
          sreg_next = in_data;
          cnt_next  = '0;
        end else begin
          sreg_next     = sreg_shifted;
          cnt_next      = '0;
          state_next    = ST_IDLE;
          underrun_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = !hold_full_reg;
  assign busy      = (state_reg == ST_SHIFT);
  assign bit_valid = busy;
  assign bit_out   = (state_reg == ST_SHIFT) ? sreg_reg[OUT_IDX] : IDLE_BIT;
  assign underrun  = underrun_reg;

endmodule
